inst_prefetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the CPU core's instruction-decode input. It issues word fetches to instruction memory over a request/grant handshake and accepts in-order read responses. Fetched words are buffered with their PCs in a small FIFO and presented to decode over a valid/ready interface. Taken jumps and branches redirect the fetch PC, flush the buffer and discard in-flight responses.

---
 rtl/inst_prefetch_unit_if.sv | 23 ++
 rtl/inst_prefetch_unit.sv | 70 +++++++
 tb/tb_inst_prefetch_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_unit_if.sv
// inst_prefetch_unit_if: fetch control, instruction-memory and decode-side signals of the prefetch unit
interface inst_prefetch_unit_if;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  modport master (
    input  halt, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
  modport slave (
    output halt, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_prefetch_unit.sv
// inst_prefetch_unit: credit-limited instruction prefetch FIFO with redirect flush and stale-response drop
module inst_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic ck_ref,
  input logic rst,
  inst_prefetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] count, pending, drop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [CW+1:0] used;
  logic          grant, push, stale, pop, err_rv;
  logic [31:0]   redir_pc;
  always_comb begin
    used           = (CW+2)'(count) + (CW+2)'(pending) + (CW+2)'(drop);
    bus.imem_req   = !rst && !bus.halt && !bus.redirect && (used < (CW+2)'(DEPTH));
    bus.imem_addr  = fetch_pc;
    bus.inst_valid = count != '0;
    bus.inst_data  = bus.inst_valid ? data_q[rd_ptr] : 32'h0000_0013;
    bus.inst_pc    = bus.inst_valid ? pc_q[rd_ptr] : 32'h0;
    grant          = bus.imem_req && bus.imem_gnt;
    stale          = bus.imem_rvalid && drop != '0;
    push           = bus.imem_rvalid && drop == '0 && pending != '0;
    pop            = bus.inst_valid && bus.inst_ready && !bus.halt;
    err_rv         = bus.imem_rvalid && drop == '0 && pending == '0;
    redir_pc       = {bus.redirect_pc[31:2], 2'b00};
  end
  always_ff @(posedge ck_ref) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      pending  <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= redir_pc;
      resp_pc  <= redir_pc;
      count    <= '0;
      pending  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      // a response arriving now retires one outstanding request, live or stale
      drop     <= drop + pending - CW'(bus.imem_rvalid && !err_rv);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      pending <= pending + CW'(grant) - CW'(push);
      drop    <= drop - CW'(stale);
    end
  end
  always_ff @(posedge ck_ref) begin
    if (!rst && !bus.redirect && push) begin
      data_q[wr_ptr] <= bus.imem_rdata;
      pc_q[wr_ptr]   <= resp_pc;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// tb_inst_prefetch_unit: scoreboard bench with a latency-configurable in-order memory model
module tb_inst_prefetch_unit;
  logic ck_ref = 1'b0;
  logic rst = 1'b1;
  inst_prefetch_unit_if bus ();
  inst_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (.ck_ref(ck_ref), .rst(rst), .bus(bus));
  always #5 ck_ref = ~ck_ref;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mq[$];
  logic [63:0] sb[$];
  int          checks = 0, failures = 0, cyc = 0, pops = 0, lat = 1;
  logic        rst_c = 1'b1, halt_c = 1'b0, redir_c = 1'b0, gnt_c = 1'b1, ready_c = 1'b1, spur_c = 1'b0;
  logic [31:0] rpc_c = 32'h0, model_pc = 32'h0;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    mreq_t m;
    @(negedge ck_ref);
    rst             = rst_c;
    bus.halt        = halt_c;
    bus.redirect    = redir_c;
    bus.redirect_pc = rpc_c;
    bus.imem_gnt    = gnt_c;
    bus.inst_ready  = ready_c;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    if (rst_c) mq.delete();
    else if (mq.size() != 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memf(m.addr);
    end else if (spur_c) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (rst_c) begin
      sb.delete();
      model_pc = 32'h0;
    end else begin
      if (bus.imem_req) check("imem_addr", 64'(bus.imem_addr), 64'(model_pc));
      if (bus.imem_req && gnt_c) begin
        mq.push_back('{bus.imem_addr, cyc + lat});
        sb.push_back({model_pc, memf(model_pc)});
        model_pc += 32'd4;
      end
      if (bus.inst_valid && ready_c && !halt_c && !redir_c) begin
        pops++;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check("head", {bus.inst_pc, bus.inst_data}, sb.pop_front());
      end
      if (redir_c) begin
        sb.delete();
        model_pc = {rpc_c[31:2], 2'b00};
      end
    end
    cyc++;
  endtask
  task automatic do_reset();
    rst_c = 1'b1; halt_c = 1'b0; redir_c = 1'b0; gnt_c = 1'b1; spur_c = 1'b0;
    repeat (3) step();
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'h0);
    check("rst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_data", 64'(bus.inst_data), 64'h13);
    check("rst_pc", 64'(bus.inst_pc), 64'h0);
    rst_c = 1'b0;
  endtask
  initial begin
    int p;
    bit found;
    bus.halt = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;
    // streaming with single-cycle memory
    lat = 1; ready_c = 1'b1;
    do_reset();
    step();
    check("first_req", 64'(bus.imem_req), 64'd1);
    step();
    check("lat_c1_valid", 64'(bus.inst_valid), 64'd0);
    step();
    check("lat_c2_valid", 64'(bus.inst_valid), 64'd1);
    check("lat_c2_pc", 64'(bus.inst_pc), 64'h0);
    p = pops;
    repeat (20) step();
    check("throughput", 64'(pops - p), 64'd20);
    // back-pressure fills the FIFO, then drains and resumes
    ready_c = 1'b0;
    do_reset();
    repeat (10) step();
    check("full_noreq", 64'(bus.imem_req), 64'd0);
    check("full_valid", 64'(bus.inst_valid), 64'd1);
    ready_c = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = bus.imem_req;
    end
    check("resume_found", 64'(found), 64'd1);
    check("resume_addr", 64'(bus.imem_addr), 64'h10);
    repeat (10) step();
    // redirect with several requests in flight on a slow memory
    lat = 3; ready_c = 1'b1;
    do_reset();
    repeat (8) step();
    redir_c = 1'b1; rpc_c = 32'h200;
    step();
    check("redir_noreq", 64'(bus.imem_req), 64'd0);
    redir_c = 1'b0;
    step();
    check("redir_req", 64'(bus.imem_req), 64'd1);
    check("redir_addr", 64'(bus.imem_addr), 64'h200);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      found = bus.inst_valid;
    end
    check("redir_found", 64'(found), 64'd1);
    check("redir_first_pc", 64'(bus.inst_pc), 64'h200);
    repeat (12) step();
    // redirect coinciding with a response and a pop while two entries are held
    lat = 1; ready_c = 1'b0;
    do_reset();
    repeat (3) step();
    ready_c = 1'b1; redir_c = 1'b1; rpc_c = 32'h303;
    step();
    check("pre_redir_valid", 64'(bus.inst_valid), 64'd1);
    check("pre_redir_rvalid", 64'(bus.imem_rvalid), 64'd1);
    redir_c = 1'b0;
    step();
    check("redir_flush", 64'(bus.inst_valid), 64'd0);
    check("redir_aligned", 64'(bus.imem_addr), 64'h300);
    repeat (10) step();
    // halt mid-stream
    lat = 2; ready_c = 1'b1;
    do_reset();
    repeat (10) step();
    halt_c = 1'b1;
    step();
    begin
      logic [63:0] held;
      held = {bus.inst_pc, bus.inst_data};
      for (int i = 0; i < 4; i++) begin
        step();
        check("halt_noreq", 64'(bus.imem_req), 64'd0);
        check("halt_head", {bus.inst_pc, bus.inst_data}, held);
      end
    end
    halt_c = 1'b0;
    repeat (15) step();
    // fetch PC wrap and a spurious response
    lat = 1; ready_c = 1'b1;
    do_reset();
    repeat (3) step();
    redir_c = 1'b1; rpc_c = 32'hFFFF_FFFC;
    step();
    redir_c = 1'b0;
    step();
    check("wrap_pre", 64'(bus.imem_addr), 64'hFFFF_FFFC);
    step();
    check("wrap_addr", 64'(bus.imem_addr), 64'h0);
    gnt_c = 1'b0; ready_c = 1'b0;
    repeat (5) step();
    spur_c = 1'b1;
    step();
    spur_c = 1'b0;
    repeat (2) step();
    ready_c = 1'b1;
    repeat (8) step();
    check("spur_drained", 64'(bus.inst_valid), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
